// File: rtl/nv_nvdla_csc_reg_pkg.sv
// Shared constants for the CSC single-register set: group status encoding,
// register offsets and ERR register bit positions.
package nv_nvdla_csc_reg_pkg;

    localparam int unsigned REG_AW = 12;
    localparam int unsigned REG_DW = 32;

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_RUNNING = 2'd1,
        GRP_PENDING = 2'd2
    } grp_state_e;

    localparam logic [REG_AW-1:0] OFF_STATUS  = 12'h000;
    localparam logic [REG_AW-1:0] OFF_POINTER = 12'h004;
    localparam logic [REG_AW-1:0] OFF_ERR     = 12'h008;

    // STATUS: one byte lane per group, state in the two LSBs of the lane
    localparam int unsigned STATUS_STRIDE = 8;
    localparam int unsigned CONSUMER_LSB  = 16;

    localparam int unsigned ERR_RO_WR    = 0;
    localparam int unsigned ERR_BAD_ADDR = 1;
    localparam int unsigned ERR_OP_EN    = 2;
    localparam int unsigned ERR_DONE     = 3;
    localparam int unsigned ERR_FLAG_W   = 4;
    localparam int unsigned ERR_CNT_LSB  = 8;
    localparam int unsigned ERR_CNT_W    = 8;
    localparam int unsigned ERR_CNT_CLR  = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/nv_nvdla_csc_grp_status.sv
// Per-group execution status tracker: IDLE -> RUNNING/PENDING -> IDLE,
// flagging op_en/done pulses that arrive in the wrong state.
module nv_nvdla_csc_grp_status
    import nv_nvdla_csc_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       op_en,
    input  logic       done,
    input  logic       is_consumer,
    output logic [1:0] status,
    output logic       err_op_en,
    output logic       err_done
);

    grp_state_e state;
    grp_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= GRP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and error pulses, all judged on the pre-edge state
    always_comb begin
        state_nxt = state;
        err_op_en = 1'b0;
        err_done  = 1'b0;
        case (state)
            GRP_IDLE: begin
                if (op_en) begin
                    state_nxt = is_consumer ? GRP_RUNNING : GRP_PENDING;
                end
                err_done = done;
            end
            GRP_PENDING: begin
                if (is_consumer) begin
                    state_nxt = GRP_RUNNING;
                end
                err_op_en = op_en;
                err_done  = done;
            end
            GRP_RUNNING: begin
                if (done) begin
                    state_nxt = GRP_IDLE;
                end
                err_op_en = op_en;
            end
            default: begin
                state_nxt = GRP_IDLE;
            end
        endcase
    end

    assign status = state;

endmodule

// File: rtl/nv_nvdla_csc_single_reg_ng.sv
// CSC producer/consumer pointer and per-group status registers.
// Optional sticky ERR/statistics register under NVDLA_CSC_REG_ERR_CHK_EN.
module nv_nvdla_csc_single_reg_ng
    import nv_nvdla_csc_reg_pkg::*;
#(
    parameter  int unsigned       NUM_GRP   = 2,
    parameter  logic [REG_AW-1:0] BASE_ADDR = 12'h000,
    localparam int unsigned       PTR_W     = $clog2(NUM_GRP)
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [REG_AW-1:0]      reg_offset,
    input  logic [REG_DW-1:0]      reg_wr_data,
    input  logic                   reg_wr_en,
    output logic [REG_DW-1:0]      reg_rd_data,
    output logic [PTR_W-1:0]       producer,
    input  logic [PTR_W-1:0]       consumer,
    input  logic [NUM_GRP-1:0]     grp_op_en,
    input  logic [NUM_GRP-1:0]     grp_done,
    output logic [2*NUM_GRP-1:0]   grp_status
);

    logic hit_status;
    logic hit_pointer;
    logic hit_any;

    logic [NUM_GRP-1:0] err_op_en_v;
    logic [NUM_GRP-1:0] err_done_v;

    assign hit_status  = (reg_offset == BASE_ADDR + OFF_STATUS);
    assign hit_pointer = (reg_offset == BASE_ADDR + OFF_POINTER);

    // Producer pointer, written by the CPU independently of FSM events
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            producer <= '0;
        end else if (reg_wr_en && hit_pointer) begin
            producer <= reg_wr_data[PTR_W-1:0];
        end
    end

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        nv_nvdla_csc_grp_status u_grp_status (
            .clk         (nvdla_core_clk),
            .rstn        (nvdla_core_rstn),
            .op_en       (grp_op_en[g]),
            .done        (grp_done[g]),
            .is_consumer (consumer == PTR_W'(g)),
            .status      (grp_status[2*g +: 2]),
            .err_op_en   (err_op_en_v[g]),
            .err_done    (err_done_v[g])
        );
    end

`ifdef NVDLA_CSC_REG_ERR_CHK_EN
    logic                  hit_err;
    logic [ERR_FLAG_W-1:0] err_flags;
    logic [ERR_CNT_W-1:0]  err_cnt;
    logic [ERR_FLAG_W-1:0] err_set_c;
    logic [ERR_FLAG_W-1:0] err_clr_c;
    logic                  cnt_inc_c;
    logic                  cnt_clr_c;
    logic [REG_DW-1:0]     err_rdata;
    logic                  unused_wr_bits;

    assign hit_err = (reg_offset == BASE_ADDR + OFF_ERR);
    assign hit_any = hit_status | hit_pointer | hit_err;

    always_comb begin
        err_set_c               = '0;
        err_set_c[ERR_RO_WR]    = reg_wr_en & hit_status;
        err_set_c[ERR_BAD_ADDR] = reg_wr_en & ~hit_any;
        err_set_c[ERR_OP_EN]    = |err_op_en_v;
        err_set_c[ERR_DONE]     = |err_done_v;
        err_clr_c = (reg_wr_en && hit_err) ? reg_wr_data[ERR_FLAG_W-1:0] : '0;
        cnt_clr_c = reg_wr_en & hit_err & reg_wr_data[ERR_CNT_CLR];
        cnt_inc_c = err_set_c[ERR_RO_WR] | err_set_c[ERR_BAD_ADDR];
    end

    // Set beats a same-cycle write-1-to-clear
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            err_flags <= '0;
            err_cnt   <= '0;
        end else begin
            err_flags <= (err_flags & ~err_clr_c) | err_set_c;
            if (cnt_inc_c) begin
                if (err_cnt != ERR_CNT_MAX) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end else if (cnt_clr_c) begin
                err_cnt <= '0;
            end
        end
    end

    assign err_rdata = {16'h0000, err_cnt, 4'h0, err_flags};
    assign unused_wr_bits = ^reg_wr_data;
`else
    logic unused_err_bits;

    assign hit_any = hit_status | hit_pointer;
    assign unused_err_bits = ^{reg_wr_data, err_op_en_v, err_done_v, hit_any};
`endif

    // Read mux: combinational view of the state registered at the last edge
    always_comb begin
        reg_rd_data = '0;
        if (hit_status) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                reg_rd_data[STATUS_STRIDE*g +: 2] = grp_status[2*g +: 2];
            end
        end else if (hit_pointer) begin
            reg_rd_data[PTR_W-1:0]             = producer;
            reg_rd_data[CONSUMER_LSB +: PTR_W] = consumer;
        end
`ifdef NVDLA_CSC_REG_ERR_CHK_EN
        else if (hit_err) begin
            reg_rd_data = err_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_nv_nvdla_csc_single_reg_ng.sv
// Scoreboard bench for nv_nvdla_csc_single_reg_ng with four groups.
// ERR expectations follow NVDLA_CSC_REG_ERR_CHK_EN.
module tb_nv_nvdla_csc_single_reg_ng;

    localparam int unsigned NG = 4;
    localparam int unsigned PW = 2;
`ifdef NVDLA_CSC_REG_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic [11:0]      reg_offset;
    logic [31:0]      reg_wr_data;
    logic             reg_wr_en;
    logic [31:0]      reg_rd_data;
    logic [PW-1:0]    producer;
    logic [PW-1:0]    consumer;
    logic [NG-1:0]    grp_op_en;
    logic [NG-1:0]    grp_done;
    logic [2*NG-1:0]  grp_status;

    int checks = 0;
    int errors = 0;

    logic [11:0] off_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    nv_nvdla_csc_single_reg_ng #(.NUM_GRP(NG), .BASE_ADDR(12'h000)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .reg_offset      (reg_offset),
        .reg_wr_data     (reg_wr_data),
        .reg_wr_en       (reg_wr_en),
        .reg_rd_data     (reg_rd_data),
        .producer        (producer),
        .consumer        (consumer),
        .grp_op_en       (grp_op_en),
        .grp_done        (grp_done),
        .grp_status      (grp_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] data);
        reg_offset  = off;
        reg_wr_data = data;
        reg_wr_en   = 1'b1;
        tick();
        reg_wr_en   = 1'b0;
        reg_wr_data = '0;
    endtask

    task automatic pulse(input logic [NG-1:0] op, input logic [NG-1:0] dn);
        grp_op_en = op;
        grp_done  = dn;
        tick();
        grp_op_en = '0;
        grp_done  = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; reg_offset = '0; reg_wr_data = '0; reg_wr_en = 1'b0;
        consumer = '0; grp_op_en = '0; grp_done = '0;
        tick(); tick();
        rstn = 1'b1;
        checks++;
        if (producer !== 2'd0) begin
            errors++; $display("FAIL reset_producer got=%0d exp=0", producer);
        end
        checks++;
        if (grp_status !== 8'h00) begin
            errors++; $display("FAIL reset_grp_status got=%h exp=00", grp_status);
        end
        off_q.push_back(12'h000); exp_q.push_back(32'h0);
        off_q.push_back(12'h004); exp_q.push_back(32'h0);
        off_q.push_back(12'h008); exp_q.push_back(32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL reset_read off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        wr(12'h004, 32'h1);
        consumer = 2'd0;
        off_q.push_back(12'h004); exp_q.push_back(32'h0000_0001);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL ptr_write off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        checks++;
        if (producer !== 2'd1) begin
            errors++; $display("FAIL ptr_producer got=%0d exp=1", producer);
        end
    endtask

    task automatic test_pointer();
        wr(12'h004, 32'hFFFF_FFFF);
        checks++;
        if (producer !== 2'd3) begin
            errors++; $display("FAIL ptr_mask got=%0d exp=3", producer);
        end
        for (int c = 0; c < 4; c++) begin
            consumer = PW'(c);
            off_q.push_back(12'h004); exp_q.push_back({14'h0, PW'(c), 14'h0, 2'd3});
            while (off_q.size() > 0) begin
                reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
                if (reg_rd_data !== exp_v) begin
                    errors++; $display("FAIL ptr_consumer c=%0d got=%h exp=%h", c, reg_rd_data, exp_v);
                end
            end
            tick();
        end
        wr(12'h004, 32'h0);
        consumer = 2'd0;
    endtask

    task automatic test_run_done();
        consumer = 2'd2;
        pulse(4'b0100, 4'b0000);
        checks++;
        if (grp_status !== 8'h10) begin
            errors++; $display("FAIL run_grp_status got=%h exp=10", grp_status);
        end
        off_q.push_back(12'h000); exp_q.push_back(32'h0001_0000);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL run_status got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
        pulse(4'b0000, 4'b0100);
        off_q.push_back(12'h000); exp_q.push_back(32'h0);
        off_q.push_back(12'h008); exp_q.push_back(32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL done_status off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
    endtask

    task automatic test_pending();
        consumer = 2'd0;
        pulse(4'b0010, 4'b0000);
        checks++;
        if (grp_status !== 8'h08) begin
            errors++; $display("FAIL pend_grp_status got=%h exp=08", grp_status);
        end
        pulse(4'b0010, 4'b0000);
        off_q.push_back(12'h000); exp_q.push_back(32'h0000_0200);
        off_q.push_back(12'h008); exp_q.push_back(ERR_EN ? 32'h4 : 32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL pend_read off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'h4);
        consumer = 2'd1;
        tick();
        off_q.push_back(12'h000); exp_q.push_back(32'h0000_0100);
        off_q.push_back(12'h008); exp_q.push_back(32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL pend_to_run off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        pulse(4'b0000, 4'b0010);
    endtask

    task automatic test_simultaneous();
        consumer = 2'd3;
        pulse(4'b1000, 4'b0000);
        off_q.push_back(12'h000); exp_q.push_back(32'h0100_0000);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL simul_run got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
        pulse(4'b1000, 4'b1000);
        off_q.push_back(12'h000); exp_q.push_back(32'h0);
        off_q.push_back(12'h008); exp_q.push_back(ERR_EN ? 32'h4 : 32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL simul_opdone off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'h4);
        pulse(4'b0000, 4'b0001);
        off_q.push_back(12'h000); exp_q.push_back(32'h0);
        off_q.push_back(12'h008); exp_q.push_back(ERR_EN ? 32'h8 : 32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL done_idle off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'hF);
        off_q.push_back(12'h008); exp_q.push_back(32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_w1c got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
    endtask

    task automatic test_ptr_with_event();
        consumer = 2'd0;
        reg_offset = 12'h004; reg_wr_data = 32'h2; reg_wr_en = 1'b1; grp_op_en = 4'b0001;
        tick();
        reg_wr_en = 1'b0; reg_wr_data = '0; grp_op_en = '0;
        checks++;
        if (producer !== 2'd2) begin
            errors++; $display("FAIL ptr_evt_producer got=%0d exp=2", producer);
        end
        off_q.push_back(12'h004); exp_q.push_back(32'h0000_0002);
        off_q.push_back(12'h000); exp_q.push_back(32'h0000_0001);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL ptr_evt off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        pulse(4'b0000, 4'b0001);
        wr(12'h004, 32'h0);
    endtask

    task automatic test_invalid_writes();
        wr(12'h000, 32'hFFFF_FFFF);
        wr(12'h0FC, 32'hFFFF_FFFF);
        off_q.push_back(12'h000); exp_q.push_back(32'h0);
        off_q.push_back(12'h0FC); exp_q.push_back(32'h0);
        off_q.push_back(12'h008); exp_q.push_back(ERR_EN ? 32'h0000_0203 : 32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL invalid_wr off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'h0000_010F);
        off_q.push_back(12'h008); exp_q.push_back(32'h0);
        off_q.push_back(12'h004); exp_q.push_back(32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_clear off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
    endtask

`ifdef NVDLA_CSC_REG_ERR_CHK_EN
    task automatic test_err_stats();
        for (int i = 0; i < 260; i++) begin
            wr(12'h000, 32'h0);
        end
        off_q.push_back(12'h008); exp_q.push_back(32'h0000_FF01);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_saturate got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
        wr(12'h0FC, 32'h0);
        off_q.push_back(12'h008); exp_q.push_back(32'h0000_FF03);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_bad_addr got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'h2);
        off_q.push_back(12'h008); exp_q.push_back(32'h0000_FF01);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_clr_bit1 got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'h100);
        off_q.push_back(12'h008); exp_q.push_back(32'h0000_0001);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_clr_cnt got=%h exp=%h", reg_rd_data, exp_v);
            end
        end
        wr(12'h008, 32'h1);
        consumer = 2'd0;
        pulse(4'b0001, 4'b0000);
        reg_offset = 12'h008; reg_wr_data = 32'h4; reg_wr_en = 1'b1; grp_op_en = 4'b0001;
        tick();
        reg_wr_en = 1'b0; reg_wr_data = '0; grp_op_en = '0;
        off_q.push_back(12'h008); exp_q.push_back(32'h0000_0004);
        off_q.push_back(12'h000); exp_q.push_back(32'h0000_0001);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL err_set_wins off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
        pulse(4'b0000, 4'b0001);
        wr(12'h008, 32'h4);
    endtask
`endif

    task automatic test_reset_mid();
        consumer = 2'd0;
        pulse(4'b0001, 4'b0000);
        pulse(4'b0100, 4'b0000);
        wr(12'h004, 32'h1);
        checks++;
        if (producer !== 2'd1 || grp_status !== 8'h21) begin
            errors++; $display("FAIL pre_reset got=%0d/%h exp=1/21", producer, grp_status);
        end
        rstn = 1'b0;
        reg_offset = 12'h004; reg_wr_data = 32'h3; reg_wr_en = 1'b1; grp_op_en = 4'b0010;
        tick();
        rstn = 1'b1; reg_wr_en = 1'b0; reg_wr_data = '0; grp_op_en = '0;
        checks++;
        if (producer !== 2'd0 || grp_status !== 8'h00) begin
            errors++; $display("FAIL mid_reset got=%0d/%h exp=0/00", producer, grp_status);
        end
        off_q.push_back(12'h000); exp_q.push_back(32'h0);
        off_q.push_back(12'h004); exp_q.push_back(32'h0);
        off_q.push_back(12'h008); exp_q.push_back(32'h0);
        while (off_q.size() > 0) begin
            reg_offset = off_q.pop_front(); #1; exp_v = exp_q.pop_front(); checks++;
            if (reg_rd_data !== exp_v) begin
                errors++; $display("FAIL mid_reset_read off=%h got=%h exp=%h", reg_offset, reg_rd_data, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pointer();
        test_run_done();
        test_pending();
        test_simultaneous();
        test_ptr_with_event();
        test_invalid_writes();
`ifdef NVDLA_CSC_REG_ERR_CHK_EN
        test_err_stats();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
